// File: rtl/fft_stage_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// fft_stage_sequencer_pkg
// Shared types and derived constants for the FFT stage sequencer.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package fft_stage_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SCRAMBLE = 3'd1,
    ST_LAUNCH   = 3'd2,
    ST_RUN      = 3'd3,
    ST_FINISH   = 3'd4,
    ST_ERROR    = 3'd5
  } seq_state_t;

  // Number of radix-2 butterfly stages for a transform of fft_size points.
  function automatic int calc_num_stages(input int fft_size);
    return $clog2(fft_size);
  endfunction

  // Width of the stage index; never narrower than one bit.
  function automatic int calc_stage_w(input int fft_size);
    int n;
    n = $clog2(fft_size);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // The two ping-pong banks start at word 0 and at word fft_size.
  localparam int BANK_LO = 0;

  function automatic int bank_hi(input int fft_size);
    return fft_size;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fft_stage_sequencer_if.sv
// ---------------------------------------------------------------------------
// fft_stage_sequencer_if
// Control/status bundle between the sequencer and its sub-blocks/host.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface fft_stage_sequencer_if
  import fft_stage_sequencer_pkg::*;
#(
  parameter int FFT_SIZE  = 4,
  parameter int ADDR_SIZE = 5
) ();

  localparam int STAGE_W = calc_stage_w(FFT_SIZE);

  logic                 i_start;
  logic                 i_scr_done;
  logic                 i_bfly_done;
  logic                 o_scr_rst;
  logic                 o_bfly_rst;
  logic                 o_mem_sel;
  logic [STAGE_W-1:0]   o_stage;
  logic [ADDR_SIZE-1:0] o_rd_base;
  logic [ADDR_SIZE-1:0] o_wr_base;
  logic                 o_busy;
  logic                 o_done;
  logic                 o_error;

  // Sequencer side.
  modport master (
    input  i_start, i_scr_done, i_bfly_done,
    output o_scr_rst, o_bfly_rst, o_mem_sel, o_stage,
    output o_rd_base, o_wr_base, o_busy, o_done, o_error
  );

  // Host / sub-block side.
  modport slave (
    output i_start, i_scr_done, i_bfly_done,
    input  o_scr_rst, o_bfly_rst, o_mem_sel, o_stage,
    input  o_rd_base, o_wr_base, o_busy, o_done, o_error
  );

endinterface

`default_nettype wire

// File: rtl/fft_watchdog.sv
// ---------------------------------------------------------------------------
// fft_watchdog
// Clearable, enabled saturating cycle counter. "expired" is raised during
// the TIMEOUT-th enabled cycle since the last clear.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module fft_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  wire logic i_CLK,
  input  wire logic i_RST,
  input  wire logic clear,
  input  wire logic enable,
  output logic      expired
);

  localparam int               CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SAT   = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] count;

  // Count enabled cycles, holding at TIMEOUT so the flag cannot wrap away.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != SAT)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = enable && (count >= LAST);

endmodule

`default_nettype wire

// File: rtl/fft_stage_sequencer.sv
// ---------------------------------------------------------------------------
// fft_stage_sequencer
// Sequences bit-reverse scramble then log2(N) butterfly stages over two
// ping-pong memory banks, with a per-sub-stage watchdog.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module fft_stage_sequencer
  import fft_stage_sequencer_pkg::*;
#(
  parameter int FFT_SIZE  = 4,
  parameter int ADDR_SIZE = 5,
  parameter int TIMEOUT   = 1024
) (
  input  wire logic             i_CLK,
  input  wire logic             i_RST,
  fft_stage_sequencer_if.master bus
);

  localparam int NUM_STAGES = calc_num_stages(FFT_SIZE);
  localparam int STAGE_W    = calc_stage_w(FFT_SIZE);

  localparam logic [STAGE_W-1:0]   LAST_STAGE = STAGE_W'(NUM_STAGES - 1);
  localparam logic [ADDR_SIZE-1:0] BASE_LO    = ADDR_SIZE'(BANK_LO);
  localparam logic [ADDR_SIZE-1:0] BASE_HI    = ADDR_SIZE'(bank_hi(FFT_SIZE));

  seq_state_t           state, state_next;
  logic                 scr_rst, scr_rst_next;
  logic                 bfly_rst, bfly_rst_next;
  logic                 mem_sel, mem_sel_next;
  logic [STAGE_W-1:0]   stage, stage_next;
  logic [ADDR_SIZE-1:0] rd_base, rd_base_next;
  logic [ADDR_SIZE-1:0] wr_base, wr_base_next;
  logic                 busy, busy_next;
  logic                 done, done_next;
  logic                 error, error_next;
  logic                 wd_clear, wd_enable, wd_expired;

  fft_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .i_CLK   (i_CLK),
    .i_RST   (i_RST),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  // State and every output are registered; reset forces the idle picture.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state    <= ST_IDLE;
      scr_rst  <= 1'b1;
      bfly_rst <= 1'b1;
      mem_sel  <= 1'b0;
      stage    <= '0;
      rd_base  <= BASE_LO;
      wr_base  <= BASE_HI;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      state    <= state_next;
      scr_rst  <= scr_rst_next;
      bfly_rst <= bfly_rst_next;
      mem_sel  <= mem_sel_next;
      stage    <= stage_next;
      rd_base  <= rd_base_next;
      wr_base  <= wr_base_next;
      busy     <= busy_next;
      done     <= done_next;
      error    <= error_next;
    end
  end

  // Next-state and next-output decisions; a done flag beats a same-cycle timeout.
  always_comb begin
    state_next    = state;
    scr_rst_next  = scr_rst;
    bfly_rst_next = bfly_rst;
    mem_sel_next  = mem_sel;
    stage_next    = stage;
    rd_base_next  = rd_base;
    wr_base_next  = wr_base;
    busy_next     = busy;
    done_next     = 1'b0;
    error_next    = error;
    wd_clear      = 1'b0;
    wd_enable     = 1'b0;

    case (state)
      ST_IDLE, ST_ERROR: begin
        if (bus.i_start) begin
          state_next    = ST_SCRAMBLE;
          scr_rst_next  = 1'b0;
          bfly_rst_next = 1'b1;
          mem_sel_next  = 1'b0;
          rd_base_next  = BASE_LO;
          wr_base_next  = BASE_HI;
          busy_next     = 1'b1;
          error_next    = 1'b0;
          wd_clear      = 1'b1;
        end
      end

      ST_SCRAMBLE: begin
        wd_enable = 1'b1;
        if (bus.i_scr_done) begin
          state_next   = ST_LAUNCH;
          scr_rst_next = 1'b1;
          stage_next   = '0;
          rd_base_next = BASE_HI;
          wr_base_next = BASE_LO;
          mem_sel_next = 1'b1;
        end else if (wd_expired) begin
          state_next    = ST_ERROR;
          scr_rst_next  = 1'b1;
          bfly_rst_next = 1'b1;
          error_next    = 1'b1;
          busy_next     = 1'b0;
        end
      end

      // One idle cycle for the butterfly engine before it is released.
      ST_LAUNCH: begin
        state_next    = ST_RUN;
        bfly_rst_next = 1'b0;
        wd_clear      = 1'b1;
      end

      ST_RUN: begin
        wd_enable = 1'b1;
        if (bus.i_bfly_done) begin
          bfly_rst_next = 1'b1;
          rd_base_next  = wr_base;
          wr_base_next  = rd_base;
          if (stage == LAST_STAGE) begin
            state_next = ST_FINISH;
            done_next  = 1'b1;
            busy_next  = 1'b0;
          end else begin
            state_next = ST_LAUNCH;
            stage_next = stage + STAGE_W'(1);
          end
        end else if (wd_expired) begin
          state_next    = ST_ERROR;
          scr_rst_next  = 1'b1;
          bfly_rst_next = 1'b1;
          error_next    = 1'b1;
          busy_next     = 1'b0;
        end
      end

      ST_FINISH: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign bus.o_scr_rst  = scr_rst;
  assign bus.o_bfly_rst = bfly_rst;
  assign bus.o_mem_sel  = mem_sel;
  assign bus.o_stage    = stage;
  assign bus.o_rd_base  = rd_base;
  assign bus.o_wr_base  = wr_base;
  assign bus.o_busy     = busy;
  assign bus.o_done     = done;
  assign bus.o_error    = error;

endmodule

`default_nettype wire
